// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium receive-side decryptor.
//   BYTE_W        : width of ciphertext, keystream and plaintext bytes
//   state_t       : handshake FSM states (IDLE, CONSUME, SETTLE)
//   DEF_DEPTH     : default plaintext FIFO depth
//   DEF_CNT_W     : default width of the decrypted-byte counter
//   DEF_STALL_MAX : default keystream-starvation threshold in cycles
package trivium_pkg;

   localparam int BYTE_W        = 8;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_CNT_W     = 16;
   localparam int DEF_STALL_MAX = 1023;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONSUME = 2'd1,
      SETTLE  = 2'd2
   } state_t;

endpackage

// File: rtl/trivium_stream_decrypt_fifo.sv
// Synchronous show-ahead byte FIFO holding recovered plaintext.
//   clk   : system clock
//   rst   : synchronous active-high reset, discards all entries
//   push  : write din this cycle (honoured when not full, or when full and popping)
//   din   : byte to write
//   pop   : remove the head entry this cycle (ignored when empty)
//   dout  : head entry, valid whenever empty is low
//   empty : no entries stored
//   full  : DEPTH entries stored
module sync_byte_fifo
   import trivium_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic [BYTE_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by plain overflow.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; emptiness is tracked by count, so stale data is never visible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/trivium_stream_decrypt.sv
// Receive-side Trivium decryptor: XORs each accepted ciphertext byte with one
// keystream byte and buffers the plaintext in a show-ahead FIFO.
//   clk, rst      : system clock, synchronous active-high reset
//   ct_data/valid : ciphertext byte from the upstream source, held until accepted
//   ct_ready      : ciphertext accepted this cycle when ct_valid is high
//   ks_byte/valid : current keystream byte from the generator
//   ks_read       : one-cycle pulse telling the generator its byte was used
//   pt_data/valid : plaintext at the FIFO head
//   pt_ready      : consumer takes pt_data
//   byte_count    : bytes decrypted, modulo 2^CNT_W
//   ks_timeout    : sticky keystream-starvation flag
//   clear_status  : zeroes byte_count and ks_timeout
module trivium_stream_decrypt
   import trivium_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int STALL_MAX = DEF_STALL_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] ct_data,
   input  logic              ct_valid,
   output logic              ct_ready,
   input  logic [BYTE_W-1:0] ks_byte,
   input  logic              ks_valid,
   output logic              ks_read,
   output logic [BYTE_W-1:0] pt_data,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic [CNT_W-1:0]  byte_count,
   output logic              ks_timeout,
   input  logic              clear_status
);

   localparam int                 STALL_W    = $clog2(STALL_MAX + 1);
   localparam logic [STALL_W-1:0] STALL_TOP  = STALL_W'(STALL_MAX);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

   state_t            state;
   logic              accept;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              stall;
   logic [BYTE_W-1:0] fifo_dout;
   logic [STALL_W-1:0] stall_cnt;

   assign pt_valid = !fifo_empty;
   // Drive zero rather than stale storage while nothing is buffered.
   assign pt_data  = fifo_empty ? '0 : fifo_dout;
   assign pop      = pt_valid && pt_ready;
   // Ready may ride on a same-cycle pop so a full FIFO keeps streaming.
   assign ct_ready = !rst && (state == IDLE) && ks_valid && (!fifo_full || pop);
   assign accept   = ct_valid && ct_ready;
   assign stall    = (state == IDLE) && ct_valid && !ks_valid;

   sync_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (ct_data ^ ks_byte),
      .pop   (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // CONSUME pulses ks_read; SETTLE gives the generator a cycle to present
   // its next byte before ks_valid is trusted again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ks_read <= 1'b0;
      end else begin
         ks_read <= accept;
         case (state)
            IDLE:    if (accept) state <= CONSUME;
            CONSUME: state <= SETTLE;
            SETTLE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_count <= '0;
      end else if (clear_status) begin
         byte_count <= accept ? CNT_W'(1) : '0;
      end else if (accept) begin
         byte_count <= byte_count + 1'b1;
      end
   end

   // Starvation only counts while a byte is waiting on a missing keystream;
   // a full FIFO with keystream available is ordinary backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         ks_timeout <= 1'b0;
      end else begin
         if (!stall)                    stall_cnt <= '0;
         else if (stall_cnt != STALL_TOP) stall_cnt <= stall_cnt + 1'b1;

         // Setting wins over a simultaneous clear so a starvation event is never lost.
         if (stall && (stall_cnt >= STALL_LAST)) ks_timeout <= 1'b1;
         else if (clear_status)                  ks_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// Directed self-checking bench for trivium_stream_decrypt (DEPTH=4, CNT_W=4,
// STALL_MAX=8). Inputs change and outputs are sampled around the falling edge.
module tb_trivium_stream_decrypt;
   import trivium_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ct_data;
   logic       ct_valid;
   logic       ct_ready;
   logic [7:0] ks_byte;
   logic       ks_valid;
   logic       ks_read;
   logic [7:0] pt_data;
   logic       pt_valid;
   logic       pt_ready;
   logic [3:0] byte_count;
   logic       ks_timeout;
   logic       clear_status;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ks_tab [64];
   logic [7:0] ct_vals [32];
   logic [7:0] exp_q [$];
   int         acc_cyc [$];
   int         ks_idx    = 0;
   int         ks_pulses = 0;
   int         ct_seq    = 0;
   int         cyc       = 0;
   int         bc_exp    = 0;
   int         last_acc  = 0;
   int         ks_mark   = 0;
   bit         gen_on    = 1'b0;

   always #5 clk = ~clk;

   trivium_stream_decrypt #(
      .DEPTH     (4),
      .CNT_W     (4),
      .STALL_MAX (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ct_data      (ct_data),
      .ct_valid     (ct_valid),
      .ct_ready     (ct_ready),
      .ks_byte      (ks_byte),
      .ks_valid     (ks_valid),
      .ks_read      (ks_read),
      .pt_data      (pt_data),
      .pt_valid     (pt_valid),
      .pt_ready     (pt_ready),
      .byte_count   (byte_count),
      .ks_timeout   (ks_timeout),
      .clear_status (clear_status)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance to the next falling edge; emulate the generator stepping on ks_read.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (ks_read) begin
         ks_pulses++;
         if (gen_on) begin
            ks_idx++;
            ks_byte = ks_tab[ks_idx % 64];
         end
      end
   endtask

   // Offer n ciphertext bytes (bounded by max_cyc), scoreboarding every pop.
   task automatic offer(input int n, input int max_cyc);
      int acc_n = 0;
      int t     = 0;
      while ((acc_n < n || (pt_ready && exp_q.size() > 0)) && t < max_cyc) begin
         ct_data  = ct_vals[ct_seq % 32];
         ct_valid = (acc_n < n);
         #1;
         if (pt_valid && pt_ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", {31'b0, pt_valid}, 32'd0);
            else                   check("pop_data", {24'b0, pt_data}, {24'b0, exp_q.pop_front()});
         end
         if (ct_valid && ct_ready) begin
            exp_q.push_back(ct_data ^ ks_byte);
            acc_cyc.push_back(cyc);
            acc_n++;
            ct_seq++;
            bc_exp++;
         end
         tick();
         t++;
      end
      ct_valid = 1'b0;
      last_acc = acc_n;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) ks_tab[i] = 8'(i * 37 + 5);
      ks_tab[0] = 8'h11; ks_tab[1] = 8'h22; ks_tab[2] = 8'h33;
      for (int i = 0; i < 32; i++) ct_vals[i] = 8'(i * 13 + 8'h5B);
      ct_vals[0] = 8'h00; ct_vals[1] = 8'hFF; ct_vals[2] = 8'hA5;

      // Reset state, with ks_valid high to show ct_ready is held low.
      rst = 1'b1; ct_data = 8'h00; ct_valid = 1'b1; ks_byte = 8'h00; ks_valid = 1'b1;
      pt_ready = 1'b0; clear_status = 1'b0;
      tick(); tick();
      #1;
      check("rst_ct_ready",   {31'b0, ct_ready},   32'd0);
      check("rst_ks_read",    {31'b0, ks_read},    32'd0);
      check("rst_pt_valid",   {31'b0, pt_valid},   32'd0);
      check("rst_pt_data",    {24'b0, pt_data},    32'd0);
      check("rst_byte_count", {28'b0, byte_count}, 32'd0);
      check("rst_ks_timeout", {31'b0, ks_timeout}, 32'd0);
      ct_valid = 1'b0; rst = 1'b0;
      tick();

      // Single byte: 0x5A ^ 0x3C = 0x66.
      gen_on = 1'b0; ks_byte = 8'h3C; ks_valid = 1'b1; ct_data = 8'h5A; ct_valid = 1'b1; pt_ready = 1'b1;
      ks_mark = ks_pulses;
      #1;
      check("t1_ct_ready_accept", {31'b0, ct_ready}, 32'd1);
      check("t1_ks_read_before",  {31'b0, ks_read},  32'd0);
      tick();
      ct_valid = 1'b0;
      bc_exp = 1;
      #1;
      check("t1_ks_read_pulse",  {31'b0, ks_read},    32'd1);
      check("t1_ct_ready_busy",  {31'b0, ct_ready},   32'd0);
      check("t1_pt_valid",       {31'b0, pt_valid},   32'd1);
      check("t1_pt_data",        {24'b0, pt_data},    32'h66);
      check("t1_byte_count",     {28'b0, byte_count}, 32'd1);
      tick();
      #1;
      check("t1_ks_read_end",    {31'b0, ks_read},    32'd0);
      check("t1_pt_popped",      {31'b0, pt_valid},   32'd0);
      tick(); tick();
      check("t1_ks_pulses",      32'(ks_pulses - ks_mark), 32'd1);

      // Back-to-back: 00^11, FF^22, A5^33 -> 11, DD, 96; accepts 3 cycles apart.
      gen_on = 1'b1; ks_idx = 0; ks_byte = ks_tab[0]; ct_seq = 0; pt_ready = 1'b0;
      ks_mark = ks_pulses; acc_cyc.delete();
      offer(3, 20);
      check("t2_accepts", 32'(last_acc), 32'd3);
      check("t2_gap01",   32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("t2_gap12",   32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      exp_q.delete();
      pt_ready = 1'b1;
      #1;
      check("t2_pt0", {24'b0, pt_data}, 32'h11);
      tick(); #1;
      check("t2_pt1", {24'b0, pt_data}, 32'hDD);
      tick(); #1;
      check("t2_pt2", {24'b0, pt_data}, 32'h96);
      tick(); #1;
      check("t2_drained",   {31'b0, pt_valid}, 32'd0);
      check("t2_ks_pulses", 32'(ks_pulses - ks_mark), 32'd3);
      check("t2_byte_count", {28'b0, byte_count}, 32'(bc_exp % 16));

      // Backpressure: only DEPTH bytes get in until the consumer drains.
      pt_ready = 1'b0; ks_mark = ks_pulses;
      offer(6, 30);
      check("t3_accepts_full", 32'(last_acc), 32'd4);
      ct_valid = 1'b1; #1;
      check("t3_ct_ready_full", {31'b0, ct_ready}, 32'd0);
      check("t3_ks_pulses",     32'(ks_pulses - ks_mark), 32'd4);
      pt_ready = 1'b1;
      offer(2, 60);
      check("t3_accepts_rest",  32'(last_acc), 32'd2);
      check("t3_queue_empty",   32'(exp_q.size()), 32'd0);
      check("t3_byte_count",    {28'b0, byte_count}, 32'(bc_exp % 16));
      tick(); tick(); tick();

      // Starvation: 8 stalled cycles set the sticky flag.
      ks_valid = 1'b0; ct_data = 8'h77; ct_valid = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      #1;
      check("t4_no_timeout_7", {31'b0, ks_timeout}, 32'd0);
      tick(); #1;
      check("t4_timeout_8",    {31'b0, ks_timeout}, 32'd1);
      ks_valid = 1'b1; ks_byte = 8'h0F;
      offer(1, 10);
      #1;
      check("t4_timeout_sticky", {31'b0, ks_timeout}, 32'd1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      #1;
      check("t4_timeout_clear", {31'b0, ks_timeout}, 32'd0);
      check("t4_count_clear",   {28'b0, byte_count}, 32'd0);
      bc_exp = 0;
      tick(); tick();

      // Wrap: clear coincident with an accept gives 1, then 16 more wrap to 1.
      ct_data = 8'h42; ct_valid = 1'b1; clear_status = 1'b1;
      #1;
      check("t5_ct_ready", {31'b0, ct_ready}, 32'd1);
      exp_q.push_back(8'h42 ^ ks_byte);
      tick();
      ct_valid = 1'b0; clear_status = 1'b0; bc_exp = 1;
      #1;
      check("t5_clear_accept", {28'b0, byte_count}, 32'd1);
      offer(16, 200);
      check("t5_accepts",   32'(last_acc), 32'd16);
      check("t5_wrap",      {28'b0, byte_count}, 32'd1);
      check("t5_queue",     32'(exp_q.size()), 32'd0);
      tick(); tick();

      // Reset in the CONSUME cycle with two bytes buffered.
      pt_ready = 1'b0;
      offer(2, 20);
      check("t6_buffered", 32'(last_acc), 32'd2);
      tick(); tick();
      ct_valid = 1'b1; #1;
      check("t6_accept", {31'b0, ct_ready}, 32'd1);
      tick();
      ct_valid = 1'b0; #1;
      check("t6_in_consume", {31'b0, ks_read}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; exp_q.delete();
      #1;
      check("t6_ks_read",    {31'b0, ks_read},    32'd0);
      check("t6_pt_valid",   {31'b0, pt_valid},   32'd0);
      check("t6_byte_count", {28'b0, byte_count}, 32'd0);
      gen_on = 1'b0; ks_byte = 8'h3C; ct_data = 8'h5A; ct_valid = 1'b1;
      #1;
      check("t6_idle_ready", {31'b0, ct_ready}, 32'd1);
      tick();
      ct_valid = 1'b0; #1;
      check("t6_pt_valid_after", {31'b0, pt_valid},   32'd1);
      check("t6_pt_data_after",  {24'b0, pt_data},    32'h66);
      check("t6_count_after",    {28'b0, byte_count}, 32'd1);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trivium_stream_decrypt.md
Name: trivium_stream_decrypt

Overview:
Receive-side counterpart of the UART encryptor. Takes ciphertext bytes from an upstream byte source, such as a UART receiver fed by the encrypting peer. XORs each byte with one Trivium keystream byte to recover plaintext, and buffers the plaintext in a small show-ahead FIFO for a downstream consumer. It owns the keystream consumption handshake so that exactly one keystream byte is used per ciphertext byte. It also flags keystream starvation.

Parameters:
DEPTH, 4, plaintext FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the decrypted-byte counter.
STALL_MAX, 1023, cycles ct_valid may wait on a low ks_valid before ks_timeout sets; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ct_data  in  8  ciphertext byte
ct_valid  in  1  ct_data is valid; held until accepted
ct_ready  out  1  block accepts ct_data this cycle
ks_byte  in  8  current keystream byte from the Trivium generator
ks_valid  in  1  ks_byte is valid
ks_read  out  1  one-cycle pulse: ks_byte has been consumed
pt_data  out  8  plaintext byte at the FIFO head
pt_valid  out  1  FIFO non-empty
pt_ready  in  1  consumer takes pt_data
byte_count  out  CNT_W  number of bytes decrypted, modulo 2^CNT_W
ks_timeout  out  1  sticky flag for keystream starvation
clear_status  in  1  clears byte_count and ks_timeout

Behaviour:
- Reset: synchronous, active-high, and highest priority, including mid-transfer.
  - All outputs go to 0, state returns to IDLE, and FIFO contents are discarded.
  - The stall counter clears.
- FSM states: IDLE, CONSUME, SETTLE.
  - IDLE: ct_ready = ks_valid && !fifo_full. On accept (ct_valid && ct_ready), go to CONSUME.
  - CONSUME: ks_read = 1 for exactly this cycle; ct_ready = 0; next state is SETTLE.
  - SETTLE: ct_ready = 0 and ks_valid is ignored, giving the generator one cycle to advance; next state is IDLE.
  - ks_read is 0 in IDLE and SETTLE.
- Datapath:
  - On the accept edge, ct_data ^ ks_byte is pushed into the FIFO.
  - pt_valid and pt_data are updated at the following edge, so latency is 1 cycle from accept.
- Throughput: at most 1 byte per 3 cycles.
- FIFO behaviour:
  - pt_valid = !empty, and pt_data is the head entry (show-ahead).
  - A pop happens when pt_valid && pt_ready.
  - A push and pop in the same cycle leaves the occupancy unchanged; this is legal at any occupancy, including full, when the pop frees the slot.
  - ct_ready is 0 at full unless a pop happens that cycle. ct_ready may depend combinationally on pt_ready.
  - Pointers wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits.
- byte_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- Stall counter:
  - Increments each cycle that state == IDLE && ct_valid && !ks_valid.
  - Clears to 0 when that condition is false.
  - When it reaches STALL_MAX, ks_timeout sets to 1 and stays set. The counter saturates and does not wrap.
  - A full FIFO with ks_valid high does not count as a stall.
- clear_status:
  - Zeroes byte_count and ks_timeout next edge.
  - If an accept happens in the same cycle, byte_count becomes 1.
  - Does not affect the FIFO or FSM state.
- Protocol: ct_data is sampled only on accept. A change of ct_data while not accepted has no effect.

Decomposition:
- Package trivium_pkg holds:
  - BYTE_W = 8
  - the FSM state enum (IDLE, CONSUME, SETTLE), 2-bit encoding
  - the default DEPTH, CNT_W and STALL_MAX values
- One sub-module, sync_byte_fifo:
  - synchronous, show-ahead FIFO
  - parameter DEPTH, ports clk, rst, push, din, pop, dout, empty, full
- FSM, XOR, counters and flags stay in trivium_stream_decrypt.

Test Plan:
- Single byte: ks_byte=0x3C with ks_valid=1, ct_data=0x5A with ct_valid pulsed, pt_ready=1.
  -> ct_ready=1 on the accept cycle; ks_read high exactly 1 cycle, on the next cycle; pt_data=0x66 with pt_valid=1 one cycle after accept; byte_count=1.
- Back-to-back: ct bytes 0x00, 0xFF, 0xA5 held valid; ks bytes 0x11, 0x22, 0x33, with the generator advancing after each ks_read.
  -> plaintext 0x11, 0xDD, 0x96 in order; accepts 3 cycles apart; exactly 3 ks_read pulses.
- Backpressure: pt_ready=0, DEPTH=4, 6 bytes offered.
  -> 4 accepted, ct_ready=0 thereafter, ks_read count=4. Raising pt_ready drains the bytes in order and the remaining 2 are then accepted.
- Starvation: STALL_MAX=8, ct_valid=1, ks_valid=0.
  -> ks_timeout=1 after 8 cycles and stays 1 after ks_valid rises. clear_status pulse -> ks_timeout=0.
- Wrap: CNT_W=4, 17 bytes decrypted -> byte_count=1.
- Reset mid-operation: rst asserted in the CONSUME cycle with 2 bytes buffered.
  -> next cycle ks_read=0, pt_valid=0, byte_count=0, state IDLE. The next byte decrypts correctly.
